// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Covers the FSM state encoding, the requester IDs and the latency counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_VID = 1'b1;

    // Wide enough for any legal memory latency (1..7).
    localparam int LAT_W = 3;

endpackage

// File: rtl/dmem_arbiter_lat_counter.sv
// Read-latency countdown: loads on issue, decrements while waiting, and flags
// both the final wait cycle and an exhausted count.
module lat_counter
    import dmem_arb_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the CPU memory stage and the display fetcher share
// one memory, with a starvation limit that periodically hands the slot to video.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT);

    arb_state_e     state, state_n;
    logic           lat_port;
    logic           lat_we;
    logic [AW-1:0]  lat_addr;
    logic [DW-1:0]  lat_wdata;
    logic [SW-1:0]  starve_cnt;

    logic take, grant_vid, cnt_load, cnt_dec, capture;
    logic cnt_zero, cnt_last;

    lat_counter #(.W(LAT_W)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        grant_vid = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || vid_req) begin
                    take      = 1'b1;
                    grant_vid = vid_req && (!cpu_req || starve_cnt == STARVE_LIM);
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_n = DONE;
                end else begin
                    cnt_load = 1'b1;
                    state_n  = WAIT;
                end
            end
            // An exhausted count also leaves WAIT so a bad latency cannot hang the FSM.
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_last || cnt_zero) begin
                    capture = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lat_port   <= PORT_CPU;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            starve_cnt <= '0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                lat_port  <= grant_vid ? PORT_VID : PORT_CPU;
                lat_we    <= grant_vid ? 1'b0 : cpu_we;
                lat_addr  <= grant_vid ? vid_addr : cpu_addr;
                lat_wdata <= grant_vid ? '0 : cpu_wdata;
                if (grant_vid) begin
                    starve_cnt <= '0;
                end else if (vid_req && starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (capture) begin
                if (lat_port == PORT_VID) begin
                    vid_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = mem_en ? lat_addr : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;
    assign cpu_done  = (state == DONE) && (lat_port == PORT_CPU);
    assign vid_done  = (state == DONE) && (lat_port == PORT_VID);
    assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a MEM_LAT=2 and a MEM_LAT=1 instance share the requester
// inputs, each backed by its own memory model, with completions checked against a scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, vid_addr = '0;

    logic [31:0] a_cpu_rdata, a_vid_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_cpu_done, a_cpu_stall, a_vid_done, a_mem_en, a_mem_we;
    logic [31:0] b_cpu_rdata, b_vid_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_done, b_cpu_stall, b_vid_done, b_mem_en, b_mem_we;

    int   tests_run = 0, tests_failed = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done), .cpu_stall(a_cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(a_vid_rdata), .vid_done(a_vid_done),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(b_vid_rdata), .vid_done(b_vid_done),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        if (a == 32'h44) return 32'h0000_CAFE;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory models: read data is valid for exactly one cycle, MEM_LAT cycles after the issue cycle.
    int          a_pend = 0, b_pend = 0;
    logic [31:0] a_paddr = '0, b_paddr = '0;

    always @(posedge clk) begin
        if (a_mem_en && !a_mem_we) begin
            a_paddr <= a_mem_addr;
            a_pend  <= 2;
        end else if (a_pend > 0) begin
            a_pend <= a_pend - 1;
        end
        if (b_mem_en && !b_mem_we) begin
            b_paddr <= b_mem_addr;
            b_pend  <= 1;
        end else if (b_pend > 0) begin
            b_pend <= b_pend - 1;
        end
    end

    assign a_mem_rdata = (a_pend == 1) ? word(a_paddr) : 32'hFFFF_FFFF;
    assign b_mem_rdata = (b_pend == 1) ? word(b_paddr) : 32'hFFFF_FFFF;

    task automatic do_reset();
        cpu_req = 1'b0; vid_req = 1'b0; cpu_we = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h40;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({a_mem_en, a_mem_we, a_cpu_done, a_vid_done} !== 4'b0) begin
            tests_failed++; $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {a_mem_en, a_mem_we, a_cpu_done, a_vid_done});
        end
        tests_run++;
        if ({a_mem_addr, a_mem_wdata} !== 64'h0) begin
            tests_failed++; $display("[TB] FAIL reset_bus: got %h, expected 0", {a_mem_addr, a_mem_wdata});
        end
        tests_run++;
        if ({a_cpu_rdata, a_vid_rdata} !== 64'h0) begin
            tests_failed++; $display("[TB] FAIL reset_rdata: got %h, expected 0", {a_cpu_rdata, a_vid_rdata});
        end
        tests_run++;
        if ({b_mem_en, b_mem_we, b_cpu_done, b_vid_done, b_mem_addr, b_mem_wdata, b_cpu_rdata, b_vid_rdata} !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_lat1: got nonzero outputs, expected all 0");
        end
        tests_run++;
        if ({a_cpu_stall, b_cpu_stall} !== 2'b11) begin
            tests_failed++; $display("[TB] FAIL reset_stall: got %b, expected 11", {a_cpu_stall, b_cpu_stall});
        end
        cpu_req = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_load();
        int   done_c = -1, en_n = 0, en_c = -1, stall_n = 0;
        exp_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        exp_q.push_back('{PORT_CPU, word(32'h40)});
        #1 if (a_cpu_stall) stall_n++;
        for (int c = 1; c <= 10 && done_c < 0; c++) begin
            @(negedge clk);
            if (a_mem_en) begin en_n++; en_c = c; end
            if (a_cpu_stall) stall_n++;
            if (a_cpu_done) begin
                done_c = c; cpu_req = 1'b0;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL load_sb: got completion, expected none pending");
                end else begin
                    e = exp_q.pop_front();
                    if (a_cpu_rdata !== e.data) begin
                        tests_failed++; $display("[TB] FAIL load_rdata: got %h, expected %h", a_cpu_rdata, e.data);
                    end
                end
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (a_mem_en) en_n++;
        end
        tests_run++;
        if (done_c !== 4) begin tests_failed++; $display("[TB] FAIL load_done_cycle: got %0d, expected 4", done_c); end
        tests_run++;
        if (en_n !== 1 || en_c !== 1) begin tests_failed++; $display("[TB] FAIL load_mem_en: got %0d pulses at cycle %0d, expected 1 at cycle 1", en_n, en_c); end
        tests_run++;
        if (stall_n !== 4) begin tests_failed++; $display("[TB] FAIL load_stall: got %0d stall cycles, expected 4", stall_n); end
    endtask

    task automatic test_cpu_store();
        int   done_c = -1;
        exp_t e;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h1234_5678;
        exp_q.push_back('{PORT_CPU, 32'hDEAD_BEEF});
        for (int c = 1; c <= 8 && done_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests_run++;
                if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 32'h80, 32'h1234_5678}) begin
                    tests_failed++; $display("[TB] FAIL store_issue: got en=%b we=%b addr=%h wdata=%h, expected 1 1 00000080 12345678",
                                             a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
                end
            end
            if (a_cpu_done) begin
                done_c = c; cpu_req = 1'b0; cpu_we = 1'b0;
                e = exp_q.pop_front();
                tests_run++;
                if (a_cpu_rdata !== e.data) begin tests_failed++; $display("[TB] FAIL store_rdata_kept: got %h, expected %h", a_cpu_rdata, e.data); end
            end
        end
        tests_run++;
        if (done_c !== 2) begin tests_failed++; $display("[TB] FAIL store_done_cycle: got %0d, expected 2", done_c); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int   sv = 0, n_done = 0, n_issue = 0;
        logic w;
        exp_t e;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; vid_req = 1'b1; vid_addr = 32'h300;
        for (int c = 1; c <= 80 && n_done < 10; c++) begin
            @(negedge clk);
            if (a_mem_en) begin
                w = (sv == 4) ? PORT_VID : PORT_CPU;
                sv = (w == PORT_VID) ? 0 : ((sv < 4) ? sv + 1 : sv);
                exp_q.push_back('{w, word(w == PORT_VID ? 32'h300 : 32'h200)});
                tests_run++;
                if (a_mem_addr !== (w == PORT_VID ? 32'h300 : 32'h200)) begin
                    tests_failed++; $display("[TB] FAIL grant_order[%0d]: got addr %h, expected %s", n_issue, a_mem_addr, w ? "video" : "cpu");
                end
                n_issue++;
            end
            if (a_cpu_done || a_vid_done) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("[TB] FAIL starve_sb: got completion, expected none pending");
                end else begin
                    e = exp_q.pop_front();
                    if ({a_vid_done, a_cpu_done} !== (e.port ? 2'b10 : 2'b01) ||
                        (e.port ? a_vid_rdata : a_cpu_rdata) !== e.data) begin
                        tests_failed++; $display("[TB] FAIL starve_done[%0d]: got done=%b data=%h, expected port=%b data=%h",
                                                 n_done, {a_vid_done, a_cpu_done}, e.port ? a_vid_rdata : a_cpu_rdata, e.port, e.data);
                    end
                end
                n_done++;
                if (n_done == 10) begin cpu_req = 1'b0; vid_req = 1'b0; end
            end
        end
        tests_run++;
        if (n_done !== 10) begin tests_failed++; $display("[TB] FAIL starve_count: got %0d completions, expected 10", n_done); end
        cpu_req = 1'b0; vid_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   iss[4], dn[2];
        int   n_iss = 0, n_dn = 0;
        exp_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48;
        exp_q.push_back('{PORT_CPU, word(32'h48)});
        for (int c = 1; c <= 30 && n_dn < 2; c++) begin
            @(negedge clk);
            if (a_mem_en) begin
                if (n_iss < 4) iss[n_iss] = c;
                n_iss++;
            end
            if (a_cpu_done) begin
                dn[n_dn] = c; n_dn++;
                e = exp_q.pop_front();
                tests_run++;
                if (a_cpu_rdata !== e.data) begin tests_failed++; $display("[TB] FAIL b2b_rdata[%0d]: got %h, expected %h", n_dn, a_cpu_rdata, e.data); end
                if (n_dn == 1) begin
                    cpu_addr = 32'h4C;
                    exp_q.push_back('{PORT_CPU, word(32'h4C)});
                end else begin
                    cpu_req = 1'b0;
                end
            end
        end
        tests_run++;
        if (n_iss !== 2 || n_dn !== 2) begin
            tests_failed++; $display("[TB] FAIL b2b_counts: got %0d issues %0d dones, expected 2 and 2", n_iss, n_dn);
        end else begin
            tests_run++;
            if (iss[1] !== dn[0] + 2) begin tests_failed++; $display("[TB] FAIL b2b_gap: got issue at %0d, expected %0d", iss[1], dn[0] + 2); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n_done = 0, n_en = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        repeat (2) @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            if (a_cpu_done || a_vid_done) n_done++;
            if (a_mem_en) n_en++;
            @(negedge clk);
        end
        tests_run++;
        if (n_done !== 0 || n_en !== 0) begin tests_failed++; $display("[TB] FAIL abort_quiet: got %0d dones %0d issues, expected 0 and 0", n_done, n_en); end
        tests_run++;
        if ({a_cpu_rdata, a_vid_rdata, b_cpu_rdata} !== 96'h0) begin
            tests_failed++; $display("[TB] FAIL abort_rdata: got %h %h %h, expected 0", a_cpu_rdata, a_vid_rdata, b_cpu_rdata);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h90; cpu_wdata = 32'h1;
        @(negedge clk);
        tests_run++;
        if ({a_mem_en, a_mem_we} !== 2'b11) begin tests_failed++; $display("[TB] FAIL abort_idle: got en/we %b, expected 11", {a_mem_en, a_mem_we}); end
        @(negedge clk);
        tests_run++;
        if ({a_cpu_done, a_cpu_rdata} !== {1'b1, 32'h0}) begin
            tests_failed++; $display("[TB] FAIL abort_store: got done=%b rdata=%h, expected 1 00000000", a_cpu_done, a_cpu_rdata);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vid_lat1();
        int   b_dc = -1, a_dc = -1, en_n = 0, en_c = -1, cpu_dn = 0;
        exp_t e;
        do_reset();
        vid_req = 1'b1; vid_addr = 32'h100;
        exp_q.push_back('{PORT_VID, word(32'h100)});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (b_mem_en) begin en_n++; en_c = c; end
            if (b_cpu_done || a_cpu_done) cpu_dn++;
            if (a_vid_done && a_dc < 0) a_dc = c;
            if (b_vid_done && b_dc < 0) begin
                b_dc = c; vid_req = 1'b0;
                e = exp_q.pop_front();
                tests_run++;
                if (b_vid_rdata !== e.data) begin tests_failed++; $display("[TB] FAIL lat1_rdata: got %h, expected %h", b_vid_rdata, e.data); end
            end
        end
        tests_run++;
        if (b_dc !== 3) begin tests_failed++; $display("[TB] FAIL lat1_done_cycle: got %0d, expected 3", b_dc); end
        tests_run++;
        if (en_n !== 1 || en_c !== 1) begin tests_failed++; $display("[TB] FAIL lat1_mem_en: got %0d pulses at %0d, expected 1 at 1", en_n, en_c); end
        tests_run++;
        if (a_dc !== 4 || a_vid_rdata !== word(32'h100)) begin
            tests_failed++; $display("[TB] FAIL lat2_vid: got done at %0d data %h, expected 4 and %h", a_dc, a_vid_rdata, word(32'h100));
        end
        tests_run++;
        if (cpu_dn !== 0) begin tests_failed++; $display("[TB] FAIL vid_no_cpu_done: got %0d, expected 0", cpu_dn); end
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_cpu_store();
        test_starvation();
        test_back_to_back();
        test_reset_abort();
        test_vid_lat1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion within time limit");
        $fatal(1, "[TB] time limit expired");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AW  32  address width
  DW  32  data width
  MEM_LAT  2  data-memory read latency in cycles after issue (legal 1..7)
  STARVE_MAX  4  consecutive CPU grants allowed while video waits
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-low
  cpu_req  in  1  memory-stage access request
  cpu_we  in  1  1=store, 0=load
  cpu_addr  in  AW  CPU address
  cpu_wdata  in  DW  store data
  cpu_rdata  out  DW  load data, registered
  cpu_done  out  1  one-cycle completion pulse
  cpu_stall  out  1  pipeline freeze request
  vid_req  in  1  display read request
  vid_addr  in  AW  display address
  vid_rdata  out  DW  display read data, registered
  vid_done  out  1  one-cycle completion pulse
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  AW  memory address
  mem_wdata  out  DW  memory write data
  mem_rdata  in  DW  memory read data

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE: if any req is high, the arbiter SHALL pick a winner, latch its addr/we/wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration: the CPU SHALL win, except when both request and the starve count equals STARVE_MAX, in which case video SHALL win.
REQ-006 Starve count: +1 on each CPU grant with vid_req high; cleared on a video grant; saturates at STARVE_MAX.
REQ-007 ISSUE: mem_en SHALL be 1 for exactly this cycle, with mem_addr, mem_we and mem_wdata driven from the latched values; mem_we SHALL be 0 for video.
REQ-008 Write: ISSUE SHALL go directly to DONE; the write completes 2 cycles after the req is sampled.
REQ-009 Read: a latency counter SHALL load MEM_LAT at ISSUE; the FSM SHALL wait in WAIT until mem_rdata is valid MEM_LAT cycles after ISSUE, capture it into the winner's rdata register, then go to DONE.
REQ-010 Read latency SHALL be MEM_LAT+2 cycles from the IDLE sample cycle to done; with MEM_LAT=1 the FSM spends 1 cycle in WAIT.
REQ-011 DONE: the winner's done SHALL be 1 for exactly one cycle, req inputs SHALL NOT be sampled, and the next state SHALL be IDLE.
REQ-012 cpu_stall SHALL equal cpu_req AND NOT cpu_done, combinationally.
REQ-013 Requesters SHALL hold req/addr/data stable until done; the latched copy SHALL be used regardless.
REQ-014 Each rdata register SHALL hold its value until that port's next read completes; a write SHALL NOT modify cpu_rdata.
REQ-015 mem_en SHALL be 0 in every state except ISSUE.

Reset
REQ-016 With rst low at a clock edge: state=IDLE, starve count=0, latency counter=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, cpu_rdata=vid_rdata=0, cpu_done=vid_done=0.
REQ-017 Reset during ISSUE/WAIT SHALL abort the access; no done SHALL be generated for it, and any late mem_rdata SHALL be ignored.

Structure
REQ-018 A shared package dmem_arb_pkg SHALL hold the state enum and port-ID constants (PORT_CPU=0, PORT_VID=1).
REQ-019 The latency countdown SHALL be one sub-module, lat_counter (load, decrement, zero flag).

Verification
REQ-020 CPU load at 0x40 with MEM_LAT=2 and mem returning 0xDEADBEEF -> single mem_en pulse; cpu_done at cycle 4; cpu_rdata=0xDEADBEEF; cpu_stall high for cycles 0-3.
REQ-021 CPU store 0x12345678 to 0x80 -> mem_we=1 and mem_en=1 in the ISSUE cycle; cpu_done at cycle 2; cpu_rdata unchanged.
REQ-022 cpu_req and vid_req held continuously -> grant order 4 CPU, 1 video, repeating; no starve count above 4.
REQ-023 Back-to-back CPU loads with a new request immediately after done -> second issue exactly 2 cycles after first done; no double sampling in DONE.
REQ-024 rst low during WAIT, mem_rdata=0xCAFE arriving afterward -> no done pulse; rdata stays 0; FSM in IDLE.
REQ-025 MEM_LAT=1, video read -> vid_done at cycle 3; mem_en low outside ISSUE.
